// File: rtl/sobel_gcd_pkg.sv
// Shared types and pin-field constants for the Sobel/GCD tile.
package sobel_gcd_pkg;

  typedef enum logic {
    MODE_SOBEL = 1'b0,
    MODE_GCD   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam int UIO_WR    = 0;
  localparam int UIO_MODE  = 1;
  localparam int UIO_CLR   = 2;
  localparam int UIO_BUSY  = 4;
  localparam int UIO_DONE  = 5;
  localparam int UIO_ERR   = 6;
  localparam int UIO_MECHO = 7;

  localparam logic [7:0] UIO_OE = 8'hF0;

  function automatic logic [7:0] sat8(input logic [11:0] v);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/gcd_core.sv
// Subtractive Euclid engine: one subtraction per enabled cycle.
module gcd_core
  import sobel_gcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       load_a,
  input  logic       load_b,
  input  logic [7:0] din,
  output logic       busy,
  output logic       fin,
  output logic       err,
  output logic [7:0] res
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       busy_q, busy_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    fin    = 1'b0;
    if (clr) begin
      a_d    = '0;
      b_d    = '0;
      busy_d = 1'b0;
    end else if (load_a) begin
      a_d = din;
    end else if (load_b) begin
      b_d    = din;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // a zero operand finishes at once with the other one as result
      if (a_q == b_q || a_q == 8'd0 || b_q == 8'd0) begin
        fin    = 1'b1;
        busy_d = 1'b0;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else begin
        b_d = b_q - a_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
    end else if (en) begin
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign res  = (a_q == 8'd0) ? b_q : a_q;
  assign err  = (a_q == 8'd0) && (b_q == 8'd0);

endmodule

// File: rtl/sobel_gcd_unal.sv
// Chip top: Sobel 3x3 gradient and GCD engine sharing one 8-bit pin set.
module sobel_gcd_unal
  import sobel_gcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d, mode_in;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] win_q [8];
  logic [7:0] win_d [8];
  logic [7:0] out_q, out_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       wr, clr, load_a, load_b;
  logic       g_busy, g_fin, g_err;
  logic [7:0] g_res;
  logic [7:0] px [9];
  logic [11:0] gx_p, gx_n, gy_p, gy_n, ax, ay, mag;
  logic       unused;

  assign wr      = ena & uio_in[UIO_WR] & ~uio_in[UIO_CLR];
  assign clr     = ena & uio_in[UIO_CLR];
  assign mode_in = mode_e'(uio_in[UIO_MODE]);
  assign unused  = ^uio_in[7:3];

  // the ninth pixel is taken straight from the pins on its write cycle
  always_comb begin
    for (int i = 0; i < 8; i++) px[i] = win_q[i];
    px[8] = ui_in;
    gx_p = {4'b0, px[2]} + {3'b0, px[5], 1'b0} + {4'b0, px[8]};
    gx_n = {4'b0, px[0]} + {3'b0, px[3], 1'b0} + {4'b0, px[6]};
    gy_p = {4'b0, px[6]} + {3'b0, px[7], 1'b0} + {4'b0, px[8]};
    gy_n = {4'b0, px[0]} + {3'b0, px[1], 1'b0} + {4'b0, px[2]};
    ax   = (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
    ay   = (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
    mag  = ax + ay;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    out_d   = out_q;
    done_d  = done_q;
    err_d   = err_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      mode_d  = MODE_SOBEL;
      cnt_d   = '0;
      for (int i = 0; i < 8; i++) win_d[i] = '0;
      out_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (g_fin) begin
        out_d   = g_res;
        done_d  = 1'b1;
        err_d   = g_err;
        state_d = DONE;
      end
    end else if (mode_in != mode_q) begin
      mode_d  = mode_in;
      cnt_d   = '0;
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (wr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      if (mode_q == MODE_SOBEL) begin
        if (cnt_q == 4'd8) begin
          out_d   = sat8(mag);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          win_d[cnt_q[2:0]] = ui_in;
          cnt_d   = cnt_q + 4'd1;
          state_d = LOAD;
        end
      end else if (cnt_q == 4'd0) begin
        load_a  = 1'b1;
        cnt_d   = 4'd1;
        state_d = LOAD;
      end else begin
        load_b  = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SOBEL;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) win_q[i] <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  gcd_core u_gcd (
    .clk    (clk),
    .rst    (rst_n),
    .en     (ena),
    .clr    (clr),
    .load_a (load_a),
    .load_b (load_b),
    .din    (ui_in),
    .busy   (g_busy),
    .fin    (g_fin),
    .err    (g_err),
    .res    (g_res)
  );

  assign uo_out  = out_q;
  assign uio_out = {logic'(mode_q), err_q, done_q, g_busy, 4'b0};
  assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_sobel_gcd_unal.sv
// Randomized bench for sobel_gcd_unal against an arithmetic reference.
module tb_sobel_gcd_unal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_run  = 0;
  int n_fail = 0;

  always #20 clk = ~clk;

  sobel_gcd_unal dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_sobel(input int p[9]);
    int gx, gy, m;
    gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
    gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic set_mode(input logic m);
    uio_in = {6'b0, m, 1'b0};
    @(negedge clk);
  endtask

  task automatic wr_word(input logic m, input logic [7:0] d);
    ui_in  = d;
    uio_in = {6'b0, m, 1'b1};
    @(negedge clk);
    uio_in = {6'b0, m, 1'b0};
  endtask

  task automatic run_sobel(input string tag, input int p[9]);
    set_mode(1'b0);
    for (int i = 0; i < 9; i++) wr_word(1'b0, 8'(p[i]));
    check({tag, "_mag"}, int'(uo_out), ref_sobel(p));
    check({tag, "_done"}, int'(uio_out[5]), 1);
    check({tag, "_be"}, int'({uio_out[4], uio_out[6]}), 0);
  endtask

  task automatic run_gcd(input string tag, input int a, input int b,
                         input bit poke, output int cyc);
    set_mode(1'b1);
    wr_word(1'b1, 8'(a));
    wr_word(1'b1, 8'(b));
    check({tag, "_busy"}, int'({uio_out[4], uio_out[5]}), 2);
    cyc = 0;
    if (poke) begin
      wr_word(1'b1, 8'd99);
      cyc = 1;
    end
    while (uio_out[5] !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, int'(cyc <= 255), 1);
    check({tag, "_res"}, int'(uo_out), ref_gcd(a, b));
    check({tag, "_err"}, int'(uio_out[6]), int'(a == 0 && b == 0));
    check({tag, "_idle"}, int'(uio_out[4]), 0);
  endtask

  initial begin
    int p[9];
    int cyc, ref_cyc, ga, gb;

    ena    = 1'b1;
    rst_n  = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
    end
    check("rst_uo", int'(uo_out), 0);
    check("rst_uio", int'(uio_out), 0);
    check("rst_oe", int'(uio_oe), 'hF0);
    check("rst_x", int'($isunknown({uo_out, uio_out, uio_oe})), 0);
    uio_in = 8'h00;
    ui_in  = 8'h00;
    rst_n  = 1'b0;
    @(negedge clk);

    p = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    run_sobel("sob_edge", p);
    p = '{10, 12, 14, 10, 12, 14, 10, 12, 14};
    run_sobel("sob_ramp", p);
    p = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    run_sobel("sob_flat", p);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++)
        p[i] = (k < 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      run_sobel("sob_rnd", p);
    end

    ga = int'(uo_out);
    repeat (5) @(negedge clk);
    check("hold_done", int'(uio_out[5]), 1);
    check("hold_uo", int'(uo_out), ga);
    wr_word(1'b0, 8'd7);
    check("newbatch_done", int'(uio_out[5]), 0);

    run_gcd("g48_18", 48, 18, 1'b1, cyc);
    run_gcd("g255_1", 255, 1, 1'b0, cyc);
    check("g255_1_cyc", cyc, 255);
    run_gcd("g0_7", 0, 7, 1'b0, cyc);
    check("g0_7_cyc", cyc, 1);
    run_gcd("g0_0", 0, 0, 1'b0, cyc);
    check("g0_0_cyc", cyc, 1);
    run_gcd("g7_0", 7, 0, 1'b0, cyc);
    for (int k = 0; k < 8; k++)
      run_gcd("g_rnd", int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 1'b0, cyc);

    run_gcd("g200_7", 200, 7, 1'b0, ref_cyc);
    set_mode(1'b1);
    wr_word(1'b1, 8'd200);
    wr_word(1'b1, 8'd7);
    repeat (3) @(negedge clk);
    ena    = 1'b0;
    ui_in  = 8'd55;
    uio_in = 8'b011;
    repeat (20) @(negedge clk);
    check("pause_busy", int'({uio_out[4], uio_out[5]}), 2);
    ena    = 1'b1;
    uio_in = 8'b010;
    cyc    = 3;
    while (uio_out[5] !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("pause_cyc", cyc, ref_cyc);
    check("pause_res", int'(uo_out), 1);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(0, 255));
      run_sobel("sob_after", p);
    end

    set_mode(1'b1);
    wr_word(1'b1, 8'd255);
    wr_word(1'b1, 8'd1);
    repeat (5) @(negedge clk);
    uio_in = 8'b110;
    @(negedge clk);
    check("clr_uo", int'(uo_out), 0);
    check("clr_uio", int'(uio_out), 0);
    check("clr_oe", int'(uio_oe), 'hF0);
    uio_in = 8'b010;
    run_gcd("g_postclr", 48, 18, 1'b0, cyc);

    wr_word(1'b1, 8'd255);
    wr_word(1'b1, 8'd1);
    repeat (10) @(negedge clk);
    check("mid_busy", int'(uio_out[4]), 1);
    #5 rst_n = 1'b1;
    #1;
    check("arst_uo", int'(uo_out), 0);
    check("arst_uio", int'(uio_out), 0);
    @(negedge clk);
    uio_in = 8'h00;
    rst_n  = 1'b0;
    @(negedge clk);
    run_gcd("g_postrst", 36, 60, 1'b0, cyc);
    p = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    run_sobel("sob_postrst", p);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
